friscv_dcache_fetcher: RTL

FRISCV_DCACHE_FETCHER -- requirements
Module: friscv_dcache_fetcher

---
 rtl/friscv_dcache_fetcher.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/friscv_dcache_fetcher.sv
// Data-cache read fetcher: serves one master read at a time from a cache hit or a memory fetch, filling on clean misses.
// Latency: hit answers 2 cycles after AR handshake; misses/IO wait for pending writes, then memory. Backpressure: arready only in IDLE, response held until rready.
module friscv_dcache_fetcher #(
   parameter int XLEN = 32,
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_ID_W = 8,
   parameter logic [AXI_ID_W-1:0] AXI_ID_MASK = 'h10,
   parameter int CACHE_BLOCK_W = 128,
   parameter int IO_REGION_NUMBER = 1,
   parameter logic [IO_REGION_NUMBER*2*AXI_ADDR_W-1:0] IO_MAP = 64'h001000FF_00100000
)(
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     srst,
   input  logic                     pending_wr,
   output logic                     pending_rd,
   input  logic                     mst_arvalid,
   output logic                     mst_arready,
   input  logic [AXI_ADDR_W-1:0]    mst_araddr,
   input  logic [AXI_ID_W-1:0]      mst_arid,
   output logic                     mst_rvalid,
   input  logic                     mst_rready,
   output logic [XLEN-1:0]          mst_rdata,
   output logic [AXI_ID_W-1:0]      mst_rid,
   output logic [1:0]               mst_rresp,
   output logic                     cache_ren,
   output logic [AXI_ADDR_W-1:0]    cache_raddr,
   input  logic                     cache_hit,
   input  logic                     cache_miss,
   input  logic [CACHE_BLOCK_W-1:0] cache_rdata,
   output logic                     cache_wen,
   output logic [AXI_ADDR_W-1:0]    cache_waddr,
   output logic [CACHE_BLOCK_W-1:0] cache_wdata,
   output logic                     memctrl_arvalid,
   input  logic                     memctrl_arready,
   output logic [AXI_ADDR_W-1:0]    memctrl_araddr,
   output logic [2:0]               memctrl_arprot,
   output logic [AXI_ID_W-1:0]      memctrl_arid,
   input  logic                     memctrl_rvalid,
   output logic                     memctrl_rready,
   input  logic [CACHE_BLOCK_W-1:0] memctrl_rdata,
   input  logic [AXI_ID_W-1:0]      memctrl_rid,
   input  logic [1:0]               memctrl_rresp
);

   localparam int NW   = CACHE_BLOCK_W / XLEN;
   localparam int SELW = (NW > 1) ? $clog2(NW) : 1;
   localparam int WOFF = $clog2(XLEN / 8);
   localparam int BOFF = $clog2(CACHE_BLOCK_W / 8);

   typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_WR, MEM_REQ, MEM_WAIT, RESP} state_t;

   state_t                   state, state_nxt;
   logic [AXI_ADDR_W-1:0]    addr_q;
   logic [AXI_ID_W-1:0]      id_q;
   logic                     io_q;
   logic [XLEN-1:0]          rdata_q;
   logic [AXI_ID_W-1:0]      rid_q;
   logic [1:0]               rresp_q;
   logic                     wen_q;
   logic [AXI_ADDR_W-1:0]    waddr_q;
   logic [CACHE_BLOCK_W-1:0] wdata_q;
   logic                     hs_io;
   logic                     lookup_hit;
   logic                     lookup_miss;
   logic [AXI_ADDR_W-1:0]    aligned_addr;
   logic                     unused_rid;

   function automatic logic is_io(input logic [AXI_ADDR_W-1:0] addr);
      is_io = 1'b0;
      for (int r = 0; r < IO_REGION_NUMBER; r++)
         if (addr >= IO_MAP[r*2*AXI_ADDR_W +: AXI_ADDR_W] &&
             addr <= IO_MAP[r*2*AXI_ADDR_W+AXI_ADDR_W +: AXI_ADDR_W])
            is_io = 1'b1;
   endfunction

   function automatic logic [XLEN-1:0] pick_word(input logic [CACHE_BLOCK_W-1:0] blk,
                                                 input logic [AXI_ADDR_W-1:0] addr);
      logic [SELW-1:0] idx;
      pick_word = '0;
      idx = addr[WOFF +: SELW];
      for (int i = 0; i < NW; i++)
         if (NW == 1 || idx == SELW'(i))
            pick_word = blk[i*XLEN +: XLEN];
   endfunction

   assign hs_io        = is_io(mst_araddr);
   // Both strobes together is resolved as a miss so the line gets refetched.
   assign lookup_miss  = cache_miss;
   assign lookup_hit   = cache_hit & ~cache_miss;
   assign aligned_addr = {addr_q[AXI_ADDR_W-1:BOFF], {BOFF{1'b0}}};
   assign unused_rid   = ^memctrl_rid;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (mst_arvalid) state_nxt = hs_io ? WAIT_WR : LOOKUP;
         LOOKUP:   if (lookup_miss) state_nxt = WAIT_WR;
                   else if (lookup_hit) state_nxt = RESP;
         WAIT_WR:  if (!pending_wr) state_nxt = MEM_REQ;
         MEM_REQ:  if (memctrl_arready) state_nxt = MEM_WAIT;
         MEM_WAIT: if (memctrl_rvalid) state_nxt = RESP;
         RESP:     if (mst_rready) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= IDLE;
         addr_q  <= '0;
         id_q    <= '0;
         io_q    <= 1'b0;
         rdata_q <= '0;
         rid_q   <= '0;
         rresp_q <= '0;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else if (srst) begin
         state   <= IDLE;
         addr_q  <= '0;
         id_q    <= '0;
         io_q    <= 1'b0;
         rdata_q <= '0;
         rid_q   <= '0;
         rresp_q <= '0;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_nxt;
         wen_q <= 1'b0;
         case (state)
            IDLE: if (mst_arvalid) begin
               addr_q <= mst_araddr;
               id_q   <= mst_arid;
               io_q   <= hs_io;
            end
            LOOKUP: if (lookup_hit) begin
               rdata_q <= pick_word(cache_rdata, addr_q);
               rid_q   <= id_q;
               rresp_q <= 2'b00;
            end
            MEM_WAIT: if (memctrl_rvalid) begin
               rdata_q <= pick_word(memctrl_rdata, addr_q);
               rid_q   <= id_q;
               rresp_q <= memctrl_rresp;
               // Only clean, cacheable blocks are allowed into the cache.
               if (!io_q && memctrl_rresp == 2'b00) begin
                  wen_q   <= 1'b1;
                  waddr_q <= aligned_addr;
                  wdata_q <= memctrl_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign mst_arready     = (state == IDLE);
   assign cache_ren       = (state == IDLE) & mst_arvalid & ~hs_io;
   assign cache_raddr     = cache_ren ? mst_araddr : '0;
   assign memctrl_arvalid = (state == MEM_REQ);
   assign memctrl_araddr  = memctrl_arvalid ? (io_q ? addr_q : aligned_addr) : '0;
   assign memctrl_arid    = memctrl_arvalid ? (id_q | AXI_ID_MASK) : '0;
   assign memctrl_arprot  = 3'b000;
   assign memctrl_rready  = 1'b1;
   assign mst_rvalid      = (state == RESP);
   assign mst_rdata       = rdata_q;
   assign mst_rid         = rid_q;
   assign mst_rresp       = rresp_q;
   assign cache_wen       = wen_q;
   assign cache_waddr     = waddr_q;
   assign cache_wdata     = wdata_q;
   assign pending_rd      = (state == MEM_REQ) | (state == MEM_WAIT) | wen_q;

endmodule
